// File: rtl/comp_mult_pkg.sv
// Shared definitions for the complex MAC chain: width derivation, accumulator FSM states,
// and saturation limits.
package comp_mult_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

  // Product component width produced by a DWIDTH x DWIDTH complex multiplier.
  function automatic int swidth_f(input int dwidth);
    return 2 * (dwidth + 1);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/comp_sat_add.sv
// Signed W-bit adder with optional clamp and overflow flag.
// Clamping is compiled in only when COMP_ACC_SAT_EN is defined; otherwise the add wraps.
module comp_sat_add
  import comp_mult_pkg::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum,
  output logic                o_sat
);

`ifdef COMP_ACC_SAT_EN
  localparam longint          L_MAX = sat_max(W);
  localparam longint          L_MIN = sat_min(W);
  localparam logic [W-1:0]    C_MAX = L_MAX[W-1:0];
  localparam logic [W-1:0]    C_MIN = L_MIN[W-1:0];

  logic [W:0] w_wide;
  logic       w_ovf;

  // One guard bit: the top two bits disagree exactly when the W-bit result overflows.
  assign w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};
  assign w_ovf  = w_wide[W] ^ w_wide[W-1];
  assign o_sum  = w_ovf ? (w_wide[W] ? C_MIN : C_MAX) : w_wide[W-1:0];
  assign o_sat  = w_ovf;
`else
  assign o_sum = i_a + i_b;
  assign o_sat = 1'b0;
`endif

endmodule

// File: rtl/comp_acc.sv
// Complex accumulator: sums LEN {xr,yr} products and presents the sum over val-rdy.
// Optional per-component saturation when COMP_ACC_SAT_EN is defined.
module comp_acc
  import comp_mult_pkg::*;
#(
  parameter  int DWIDTH = 8,
  parameter  int LEN    = 4,
  localparam int SWIDTH = swidth_f(DWIDTH)
) (
  input  logic                  clk,
  input  logic                  sw_rst,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [2*SWIDTH-1:0]   in_data,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [2*SWIDTH-1:0]   out_data,
  output logic [1:0]            out_sat
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  acc_state_e               r_state;
  acc_state_e               w_state_nxt;
  logic [CW-1:0]            r_cnt;
  logic signed [SWIDTH-1:0] r_xs;
  logic signed [SWIDTH-1:0] r_ys;
  logic [1:0]               r_sat;
  logic                     r_in_rdy;
  logic                     r_out_val;

  logic signed [SWIDTH-1:0] w_xs_nxt;
  logic signed [SWIDTH-1:0] w_ys_nxt;
  logic                     w_xsat;
  logic                     w_ysat;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_xfer;

  comp_sat_add #(.W(SWIDTH)) u_add_x (
    .i_a   (r_xs),
    .i_b   (in_data[2*SWIDTH-1:SWIDTH]),
    .o_sum (w_xs_nxt),
    .o_sat (w_xsat)
  );

  comp_sat_add #(.W(SWIDTH)) u_add_y (
    .i_a   (r_ys),
    .i_b   (in_data[SWIDTH-1:0]),
    .o_sum (w_ys_nxt),
    .o_sat (w_ysat)
  );

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_accept && w_last) w_state_nxt = HOLD;
      HOLD:    if (w_xfer)             w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  always_comb begin
    w_accept = (r_state == ACC) && in_val && r_in_rdy;
    w_xfer   = (r_state == HOLD) && r_out_val && out_rdy;
    w_last   = (r_cnt == CW'(LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      r_cnt     <= '0;
      r_xs      <= '0;
      r_ys      <= '0;
      r_sat     <= '0;
      r_in_rdy  <= 1'b1;
      r_out_val <= 1'b0;
    end else if (w_accept) begin
      r_xs  <= w_xs_nxt;
      r_ys  <= w_ys_nxt;
      r_sat <= r_sat | {w_xsat, w_ysat};
      if (w_last) begin
        r_cnt     <= '0;
        r_out_val <= 1'b1;
        r_in_rdy  <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (w_xfer) begin
      // Clearing here means the next frame starts from zero with no extra cycle.
      r_xs      <= '0;
      r_ys      <= '0;
      r_sat     <= '0;
      r_out_val <= 1'b0;
      r_in_rdy  <= 1'b1;
    end
  end

  assign in_rdy   = r_in_rdy;
  assign out_val  = r_out_val;
  assign out_data = {r_xs, r_ys};
  assign out_sat  = r_sat;

endmodule

// File: tb/tb_comp_acc.sv
// Randomized bench for comp_acc against a frame-level reference model, plus directed
// scenarios (LEN=4 instance and a LEN=1 instance).
module tb_comp_acc;

  localparam int DW  = 8;
  localparam int SW  = 2 * (DW + 1);
  localparam int LEN = 4;
  localparam longint MAXV = (longint'(1) <<< (SW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (SW - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            sw_rst = 1'b1;
  logic            in_val = 1'b0;
  logic            in_rdy;
  logic [2*SW-1:0] in_data = '0;
  logic            out_val;
  logic            out_rdy = 1'b0;
  logic [2*SW-1:0] out_data;
  logic [1:0]      out_sat;

  logic            b_in_val = 1'b0;
  logic            b_in_rdy;
  logic [2*SW-1:0] b_in_data = '0;
  logic            b_out_val;
  logic            b_out_rdy = 1'b0;
  logic [2*SW-1:0] b_out_data;
  logic [1:0]      b_out_sat;

  comp_acc #(.DWIDTH(DW), .LEN(LEN)) dut (
    .clk(clk), .sw_rst(sw_rst), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_sat(out_sat)
  );

  comp_acc #(.DWIDTH(DW), .LEN(1)) dut_b (
    .clk(clk), .sw_rst(sw_rst), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_data(b_in_data),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out_data(b_out_data), .out_sat(b_out_sat)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference add: ideal integer sum, then clamp or wrap into SW bits.
  function automatic longint model_add(input longint a, input longint b, output bit sat);
    longint s;
    s   = a + b;
    sat = 1'b0;
`ifdef COMP_ACC_SAT_EN
    if (s > MAXV) begin s = MAXV; sat = 1'b1; end
    else if (s < MINV) begin s = MINV; sat = 1'b1; end
`else
    while (s > MAXV) s = s - (longint'(1) <<< SW);
    while (s < MINV) s = s + (longint'(1) <<< SW);
`endif
    return s;
  endfunction

  typedef struct {
    longint     x;
    longint     y;
    logic [1:0] sat;
  } frame_t;

  frame_t q[$];
  longint fx = 0, fy = 0;
  logic [1:0] fsat = 2'b00;
  int fcnt = 0;

  // Compare current outputs against the model, then apply the events of the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_val", out_val, (q.size() > 0));
      chk("in_rdy", in_rdy, (q.size() == 0));
      if (q.size() > 0) begin
        chk("out_x", $signed(out_data[2*SW-1:SW]), q[0].x);
        chk("out_y", $signed(out_data[SW-1:0]), q[0].y);
        chk("out_sat", out_sat, q[0].sat);
      end
      if (sw_rst) begin
        q.delete();
        fx = 0; fy = 0; fsat = 2'b00; fcnt = 0;
      end else if (q.size() > 0) begin
        if (out_rdy) begin
          void'(q.pop_front());
          n_pop++;
        end
      end else if (in_val) begin
        bit sx, sy;
        fx = model_add(fx, longint'($signed(in_data[2*SW-1:SW])), sx);
        fy = model_add(fy, longint'($signed(in_data[SW-1:0])), sy);
        fsat = fsat | {sx, sy};
        fcnt++;
        if (fcnt == LEN) begin
          q.push_back('{x: fx, y: fy, sat: fsat});
          fx = 0; fy = 0; fsat = 2'b00; fcnt = 0;
        end
      end
    end
  end

  task automatic put(input int xr, input int yr);
    bit got;
    in_val  = 1'b1;
    in_data = {SW'(xr), SW'(yr)};
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      got = in_rdy;
      @(posedge clk);
      #1;
      if (got) return;
    end
    chk("put_timeout", 0, 1);
  endtask

  task automatic wait_val(input string name, output int cyc);
    cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_val) begin
        cyc = i;
        return;
      end
    end
    chk(name, 0, 1);
  endtask

  task automatic release_out();
    @(posedge clk); #1;
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  initial begin
    int cyc;
    int n0;
    bit rnd_done;

    sw_rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    @(negedge clk);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_val", out_val, 0);
    @(posedge clk); #1;

    // Basic frame
    put(1, 2); put(3, -4); put(5, 6); put(-7, 8);
    in_val = 1'b0;
    wait_val("basic_timeout", cyc);
    chk("basic_latency", cyc, 0);
    chk("basic_x", $signed(out_data[2*SW-1:SW]), 2);
    chk("basic_y", $signed(out_data[SW-1:0]), 12);
    chk("basic_sat", out_sat, 0);

    // Backpressure with in_val held high
    @(posedge clk); #1;
    in_val  = 1'b1;
    in_data = {SW'(9), SW'(9)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_x", $signed(out_data[2*SW-1:SW]), 2);
      chk("bp_in_rdy", in_rdy, 0);
    end
    release_out();
    @(negedge clk);
    chk("bp_rdy_after", in_rdy, 1);
    chk("bp_val_after", out_val, 0);
    @(posedge clk); #1;
    put(9, 9); put(1, 1); put(1, 1); put(1, 1);
    in_val = 1'b0;
    wait_val("bp2_timeout", cyc);
    chk("bp2_x", $signed(out_data[2*SW-1:SW]), 12);
    chk("bp2_y", $signed(out_data[SW-1:0]), 12);
    release_out();

    // Saturation / wrap
    put(100000, -100000); put(100000, -100000); put(0, 0); put(0, 0);
    in_val = 1'b0;
    wait_val("sat_timeout", cyc);
`ifdef COMP_ACC_SAT_EN
    chk("sat_x", $signed(out_data[2*SW-1:SW]), 131071);
    chk("sat_y", $signed(out_data[SW-1:0]), -131072);
    chk("sat_flags", out_sat, 3);
`else
    chk("wrap_x", $signed(out_data[2*SW-1:SW]), -62144);
    chk("wrap_y", $signed(out_data[SW-1:0]), 62144);
    chk("wrap_flags", out_sat, 0);
`endif
    release_out();

    // Reset mid-frame
    put(5, 5); put(5, 5);
    in_val = 1'b0;
    sw_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_val", out_val, 0);
    @(posedge clk); #1;
    sw_rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_val2", out_val, 0);
    @(posedge clk); #1;
    put(1, 1); put(1, 1); put(1, 1); put(1, 1);
    in_val = 1'b0;
    wait_val("rst_timeout", cyc);
    chk("rst_x", $signed(out_data[2*SW-1:SW]), 4);
    chk("rst_y", $signed(out_data[SW-1:0]), 4);
    release_out();

    // LEN=1 instance
    b_in_val  = 1'b1;
    b_in_data = {SW'(7), SW'(-3)};
    @(posedge clk); #1;
    b_in_val = 1'b0;
    @(negedge clk);
    chk("len1_val", b_out_val, 1);
    chk("len1_x", $signed(b_out_data[2*SW-1:SW]), 7);
    chk("len1_y", $signed(b_out_data[SW-1:0]), -3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("len1_in_rdy", b_in_rdy, 0);
    end
    @(posedge clk); #1;
    b_out_rdy = 1'b1;
    @(posedge clk); #1;
    b_out_rdy = 1'b0;
    @(negedge clk);
    chk("len1_rdy_after", b_in_rdy, 1);
    chk("len1_val_after", b_out_val, 0);
    @(posedge clk); #1;

    // Random gaps and backpressure
    n0 = n_pop;
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_rdy = ($urandom % 2) == 0;
        end
      end
      begin
        for (int f = 0; f < 100; f++) begin
          for (int k = 0; k < LEN; k++) begin
            logic [SW-1:0] rx, ry;
            in_val = 1'b0;
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk); #1;
            end
            rx = SW'($urandom);
            ry = SW'($urandom);
            put(int'($signed(rx)), int'($signed(ry)));
          end
        end
        in_val   = 1'b0;
        rnd_done = 1'b1;
      end
    join
    @(posedge clk); #1;
    out_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rand_frames", n_pop - n0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
